demux1_stream: RTL and testbench
================================

// Module: demux1_stream
// PURPOSE
//  1-to-2 streaming demultiplexer; the routing counterpart of the 2:1 select mux in the SignAdder datapath.
//  Accepts one word per cycle on a valid/ready input and steers it to output 0 or 1 by a per-word select bit.
//  Each output has a 2-entry buffer, so a stalled consumer does not create a combinational ready path to the input.
// PARAMETERS
//  W       8   data width in bits (>=1)
//  CNT_W   16  width of the optional per-output transfer counters
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      input word present
//  in_ready     out  1      input word accepted when in_valid & in_ready
//  in_sel       in   1      0 -> output 0, 1 -> output 1; sampled only on accept
//  in_data      in   W      input word
//  out0_valid   out  1      output 0 word present
//  out0_ready   in   1      output 0 consumer accepts
//  out0_data    out  W      output 0 word
//  out1_valid   out  1      output 1 word present
//  out1_ready   in   1      output 1 consumer accepts
//  out1_data    out  W      output 1 word
//  cnt0, cnt1   out  CNT_W  output transfer counts (only with DEMUX1_STATS_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): both buffers empty; out0_valid=out1_valid=0; out*_data=0; cnt0=cnt1=0.
//    A reset mid-transfer discards buffered words. Deassertion takes effect at the next clk edge.
//  - Per-output buffer state is a count: EMPTY(0), ONE(1), FULL(2).
//      EMPTY --push--> ONE
//      ONE   --push--> FULL
//      ONE   --pop-->  EMPTY
//      FULL  --pop-->  ONE
//      ONE with push and pop in the same cycle stays ONE (ordering is preserved).
//  - Push to output k happens when in_valid & in_ready & (in_sel==k). Pop from output k happens when outk_valid & outk_ready.
//  - in_ready = (count[in_sel] != FULL). It depends only on registered state and in_sel, never on outk_ready.
//    A FULL buffer rejects a push even if it is popped in the same cycle.
//  - Latency: a word accepted at edge N appears on outk_data with outk_valid=1 after edge N (one cycle).
//    There is no combinational in->out path.
//  - outk_valid = (count[k] != EMPTY). outk_data is the head entry and is held stable while outk_valid & ~outk_ready.
//  - Ordering: words are FIFO-ordered within each output. There is no ordering relation between outputs.
//  - Head-of-line blocking: if the selected output is FULL, the input stalls even if the other output has space.
//  - in_sel and in_data are don't-care while in_valid=0. X on them must not corrupt state.
//  - Both outputs may pop in the same cycle as a push to either output.
// CONFIGURATION
//  - Macro DEMUX1_STATS_EN.
//  - When defined: cnt0 and cnt1 ports exist. Each increments by 1 on every pop of its output, wraps modulo 2^CNT_W, and is cleared only by reset.
//  - When undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package kgp_risc_pkg holds the buffer count encoding (CNT_EMPTY=2'd0, CNT_ONE=2'd1, CNT_FULL=2'd2) and a DEMUX_DEPTH=2 constant.
//  - Sub-module demux1_fifo2 is a parameterised W-bit, 2-entry FIFO with push/pop/count/head ports, instantiated once per output.
//  - Top level contains only the steering logic, in_ready, and the optional counters.
// TESTING
//  1. Reset: hold rst_n=0 with random inputs -> in_ready=1, out*_valid=0, out*_data=0, cnt*=0.
//  2. Routing: send 0xA1 (sel 0) then 0xB2 (sel 1) with both readies=1 -> out0 gives 0xA1 one cycle after accept, out1 gives 0xB2 the next cycle; cnt0=cnt1=1.
//  3. Backpressure: out0_ready=0, send 0x11, 0x22, 0x33 all with sel 0 -> first two accepted, in_ready=0 on the third until one pop.
//     Then order on out0 is 0x11, 0x22, 0x33.
//  4. Head-of-line blocking: out0 FULL, present sel 1 word 0x44 -> accepted (in_ready=1).
//     Present sel 0 word 0x55 -> stalled; out1 delivers 0x44.
//  5. Simultaneous push/pop: out0 at ONE, push 0x66 while popping 0x55 -> count stays ONE and the next head is 0x66.
//  6. Reset mid-operation with both buffers FULL -> buffers empty asynchronously, valids drop without waiting for clk, counters cleared.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// rtl/kgp_risc_pkg.sv - shared buffer-count encoding and depth for the stream demux
package kgp_risc_pkg;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } fifo_cnt_e;

    localparam int DEMUX_DEPTH = 2;

endpackage

// File: rtl/demux1_stream_if.sv
// rtl/demux1_stream_if.sv - handshake bundle for the 1-to-2 stream demux
interface demux1_stream_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [W-1:0] in_data;
    logic         out0_valid;
    logic         out0_ready;
    logic [W-1:0] out0_data;
    logic         out1_valid;
    logic         out1_ready;
    logic [W-1:0] out1_data;

    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux1_fifo2.sv
// rtl/demux1_fifo2.sv - W-bit two-entry FIFO; entry 0 is always the head
module demux1_fifo2
    import kgp_risc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output fifo_cnt_e    count,
    output logic [W-1:0] head
);

    fifo_cnt_e    state_q;
    fifo_cnt_e    state_d;
    logic [W-1:0] mem [DEMUX_DEPTH];
    logic         do_push;
    logic         do_pop;

    // A full buffer refuses a push even when popped in the same cycle
    assign do_push = push & (state_q != CNT_FULL);
    assign do_pop  = pop & (state_q != CNT_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CNT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case ({do_push, do_pop})
            2'b10:   state_d = (state_q == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
            2'b01:   state_d = (state_q == CNT_FULL) ? CNT_ONE : CNT_EMPTY;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (do_pop) begin
            if (state_q == CNT_FULL) begin
                mem[0] <= mem[1];
            end else if (do_push) begin
                mem[0] <= din;
            end
        end else if (do_push) begin
            if (state_q == CNT_EMPTY) begin
                mem[0] <= din;
            end else begin
                mem[1] <= din;
            end
        end
    end

    assign count = state_q;
    assign head  = mem[0];

endmodule

// File: rtl/demux1_stream.sv
// rtl/demux1_stream.sv - 1-to-2 stream demux with 2-deep output buffers; DEMUX1_STATS_EN adds cnt0/cnt1
module demux1_stream
    import kgp_risc_pkg::*;
#(
    parameter int W = 8
`ifdef DEMUX1_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    demux1_stream_if.slave    bus
`ifdef DEMUX1_STATS_EN
    ,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
`endif
);

    fifo_cnt_e count0;
    fifo_cnt_e count1;
    fifo_cnt_e sel_count;
    logic      push0;
    logic      push1;
    logic      pop0;
    logic      pop1;

    // Ready looks only at registered fill state, so consumer ready never reaches the input
    assign sel_count    = bus.in_sel ? count1 : count0;
    assign bus.in_ready = (sel_count != CNT_FULL);

    assign push0 = bus.in_valid & bus.in_ready & ~bus.in_sel;
    assign push1 = bus.in_valid & bus.in_ready & bus.in_sel;

    assign bus.out0_valid = (count0 != CNT_EMPTY);
    assign bus.out1_valid = (count1 != CNT_EMPTY);
    assign pop0 = bus.out0_valid & bus.out0_ready;
    assign pop1 = bus.out1_valid & bus.out1_ready;

    demux1_fifo2 #(.W(W)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .din   (bus.in_data),
        .pop   (pop0),
        .count (count0),
        .head  (bus.out0_data)
    );

    demux1_fifo2 #(.W(W)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .din   (bus.in_data),
        .pop   (pop1),
        .count (count1),
        .head  (bus.out1_data)
    );

`ifdef DEMUX1_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0) cnt0 <= cnt0 + 1'b1;
            if (pop1) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux1_stream.sv
// tb/tb_demux1_stream.sv - vector table plus scoreboard bench for demux1_stream
module tb_demux1_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux1_stream_if #(.W(8)) bus ();

`ifdef DEMUX1_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    demux1_stream #(
        .W(8)
`ifdef DEMUX1_STATS_EN
        ,
        .CNT_W(16)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DEMUX1_STATS_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    typedef struct {
        logic       v;
        logic       sel;
        logic [7:0] d;
        logic       r0;
        logic       r1;
        logic       rdy;
    } vec_t;

    vec_t        tbl[$];
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [15:0] m_cnt0 = '0;
    logic [15:0] m_cnt1 = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic v, input logic sel, input logic [7:0] d,
                                    input logic r0, input logic r1, input logic rdy);
        vec_t e;
        e.v = v; e.sel = sel; e.d = d; e.r0 = r0; e.r1 = r1; e.rdy = rdy;
        tbl.push_back(e);
    endfunction

    task automatic drive(input logic v, input logic sel, input logic [7:0] d,
                         input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_sel     = sel;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_out0_valid"}, {31'd0, bus.out0_valid}, 32'd0);
        check({tag, "_out1_valid"}, {31'd0, bus.out1_valid}, 32'd0);
        check({tag, "_out0_data"}, {24'd0, bus.out0_data}, 32'd0);
        check({tag, "_out1_data"}, {24'd0, bus.out1_data}, 32'd0);
`ifdef DEMUX1_STATS_EN
        check({tag, "_cnt0"}, {16'd0, cnt0}, 32'd0);
        check({tag, "_cnt1"}, {16'd0, cnt1}, 32'd0);
`endif
    endtask

    // Compare at the falling edge, then advance the model by what the next rising edge does
    task automatic step(input logic exp_rdy, input string tag);
        logic v, sel, r0, r1;
        logic [7:0] d;
        @(negedge clk);
        v = bus.in_valid; sel = bus.in_sel; d = bus.in_data;
        r0 = bus.out0_ready; r1 = bus.out1_ready;
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        check({tag, "_out0_valid"}, {31'd0, bus.out0_valid}, {31'd0, q0.size() != 0});
        check({tag, "_out1_valid"}, {31'd0, bus.out1_valid}, {31'd0, q1.size() != 0});
        if (q0.size() != 0) check({tag, "_out0_data"}, {24'd0, bus.out0_data}, {24'd0, q0[0]});
        if (q1.size() != 0) check({tag, "_out1_data"}, {24'd0, bus.out1_data}, {24'd0, q1[0]});
`ifdef DEMUX1_STATS_EN
        check({tag, "_cnt0"}, {16'd0, cnt0}, {16'd0, m_cnt0});
        check({tag, "_cnt1"}, {16'd0, cnt1}, {16'd0, m_cnt1});
`endif
        if (q0.size() != 0 && r0) begin
            void'(q0.pop_front());
            m_cnt0 = m_cnt0 + 16'd1;
        end
        if (q1.size() != 0 && r1) begin
            void'(q1.pop_front());
            m_cnt1 = m_cnt1 + 16'd1;
        end
        if (v && exp_rdy) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_rdy;
        logic rs;

        // routing, backpressure, head-of-line blocking, push+pop at ONE, then fill both
        add_vec(1, 0, 8'hA1, 1, 1, 1);
        add_vec(1, 1, 8'hB2, 1, 1, 1);
        add_vec(0, 0, 8'h00, 1, 1, 1);
        add_vec(1, 0, 8'h11, 0, 1, 1);
        add_vec(1, 0, 8'h22, 0, 1, 1);
        add_vec(1, 0, 8'h33, 0, 1, 0);
        add_vec(1, 0, 8'h33, 0, 1, 0);
        add_vec(1, 0, 8'h33, 1, 1, 0);
        add_vec(1, 0, 8'h33, 0, 1, 1);
        add_vec(1, 1, 8'h44, 0, 0, 1);
        add_vec(1, 0, 8'h55, 0, 1, 0);
        add_vec(0, 0, 8'h00, 1, 1, 0);
        add_vec(1, 0, 8'h55, 0, 1, 1);
        add_vec(0, 0, 8'h00, 1, 1, 0);
        add_vec(1, 0, 8'h66, 1, 1, 1);
        add_vec(0, 1, 8'h00, 0, 0, 1);
        add_vec(0, 0, 8'h00, 1, 1, 1);
        add_vec(1, 0, 8'h77, 0, 0, 1);
        add_vec(1, 0, 8'h78, 0, 0, 1);
        add_vec(1, 1, 8'h79, 0, 0, 1);
        add_vec(1, 1, 8'h7A, 0, 0, 1);

        drive($urandom_range(1), $urandom_range(1), 8'($urandom), $urandom_range(1), $urandom_range(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_state("reset");
            @(posedge clk);
            #1;
            drive($urandom_range(1), 1'b0, 8'($urandom), $urandom_range(1), $urandom_range(1));
        end
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
            step(tbl[i].rdy, $sformatf("vec%0d", i));
        end

        // both buffers full: asynchronous reset mid-cycle
        check("full_q0", q0.size(), 32'd2);
        check("full_q1", q1.size(), 32'd2);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        q0.delete();
        q1.delete();
        m_cnt0 = '0;
        m_cnt1 = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            rs = 1'($urandom_range(1));
            drive($urandom_range(3) != 0, rs, 8'($urandom),
                  $urandom_range(2) != 0, $urandom_range(2) != 0);
            exp_rdy = rs ? (q1.size() != 2) : (q0.size() != 2);
            step(exp_rdy, $sformatf("rnd%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            step(1'b1, $sformatf("drain%0d", i));
        end
        check("drained_q0", q0.size(), 32'd0);
        check("drained_q1", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
